// File: rtl/vga_sync_gen_if.sv
// Scan-timing bundle from the VGA sync generator to the renderer and the
// monitor connector.
interface vga_sync_gen_if;
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;

    modport master (output p_tick, x, y, video_on, hsync, vsync, frame_tick);
    modport slave  (input  p_tick, x, y, video_on, hsync, vsync, frame_tick);
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running 640x480@60 VGA timing: pixel-enable divider, x/y scan counters,
// registered video_on/hsync/vsync and a one-clock frame_tick.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic            clk,
    input  logic            reset,
    vga_sync_gen_if.master  vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] div;
    logic [9:0]    x_nxt, y_nxt;
    logic          x_wrap, y_wrap;

    always_comb begin
        x_wrap = (vga.x == X_LAST);
        y_wrap = (vga.y == Y_LAST);
        x_nxt  = vga.x;
        y_nxt  = vga.y;
        if (vga.p_tick) begin
            x_nxt = x_wrap ? 10'd0 : vga.x + 10'd1;
            if (x_wrap)
                y_nxt = y_wrap ? 10'd0 : vga.y + 10'd1;
        end
    end

    // Decodes use the next x/y so the registered flags line up with the
    // coordinates presented in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div            <= '0;
            vga.p_tick     <= 1'b0;
            vga.x          <= '0;
            vga.y          <= '0;
            vga.video_on   <= 1'b1;
            vga.hsync      <= 1'b1;
            vga.vsync      <= 1'b1;
            vga.frame_tick <= 1'b0;
        end else begin
            div            <= (div == DIV_LAST) ? '0 : div + 1'b1;
            vga.p_tick     <= (div == DIV_LAST);
            vga.x          <= x_nxt;
            vga.y          <= y_nxt;
            vga.video_on   <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            vga.hsync      <= !((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST));
            vga.vsync      <= !((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST));
            vga.frame_tick <= vga.p_tick && x_wrap && y_wrap;
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing instance for reset/line checks, a shrunken
// instance (15x8 totals, CLK_DIV=2) so whole frames fit in a short run.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_sync_gen_if v0();
    vga_sync_gen_if v1();

    vga_sync_gen u0 (.clk(clk), .reset(reset), .vga(v0));
    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(2)
    ) u1 (.clk(clk), .reset(reset), .vga(v1));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rst_vals(input string tag);
        chk({tag, "_x"},     32'(v0.x), 0);
        chk({tag, "_y"},     32'(v0.y), 0);
        chk({tag, "_hs"},    32'(v0.hsync), 1);
        chk({tag, "_vs"},    32'(v0.vsync), 1);
        chk({tag, "_vid"},   32'(v0.video_on), 1);
        chk({tag, "_ptick"}, 32'(v0.p_tick), 0);
        chk({tag, "_ftick"}, 32'(v0.frame_tick), 0);
        chk({tag, "_s_x"},   32'(v1.x), 0);
        chk({tag, "_s_hs"},  32'(v1.hsync), 1);
    endtask

    // Asserts reset now, holds 3 clocks, releases on a falling edge and
    // follows the first five rising edges. Returns at the negedge after edge 5.
    task automatic startup(input string ph);
        int pt;
        reset = 1'b0;
        #1;
        rst_vals({ph, "_async"});
        repeat (3) @(negedge clk);
        rst_vals({ph, "_held"});
        reset = 1'b1;
        pt = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            pt += int'(v0.p_tick);
            if (k == 1) chk({ph, "_s_ptick_e1"}, 32'(v1.p_tick), 0);
            if (k == 2) chk({ph, "_s_ptick_e2"}, 32'(v1.p_tick), 1);
            if (k == 3) chk({ph, "_s_x_e3"}, 32'(v1.x), 1);
        end
        chk({ph, "_ptick_e1_3"}, 32'(pt), 0);
        @(negedge clk);
        chk({ph, "_ptick_e4"}, 32'(v0.p_tick), 1);
        chk({ph, "_x_e4"}, 32'(v0.x), 0);
        @(negedge clk);
        chk({ph, "_x_e5"}, 32'(v0.x), 1);
        chk({ph, "_ptick_e5"}, 32'(v0.p_tick), 0);
    endtask

    initial begin
        @(negedge clk);
        startup("start");

        // One full line on the default instance; c counts rising edges since release.
        begin
            int c = 5, hs_lo = 0, hs_first = -1, hs_last = -1;
            int vid_fall = -1, fall_prev_x = -1, prev_x = 1, prev_vid = 1;
            int model_err = 0, y1_at = -1, y1_x = -1, y2_at = -1, run = 0, run_err = 0;
            while (c < 4000 && y1_at < 0) begin
                @(negedge clk); c++;
                if (!v0.hsync) begin
                    hs_lo++;
                    if (hs_first < 0) hs_first = v0.x;
                    hs_last = v0.x;
                end
                if (prev_vid == 1 && !v0.video_on && vid_fall < 0) begin
                    vid_fall = v0.x; fall_prev_x = prev_x;
                end
                if (v0.hsync !== !(v0.x >= 656 && v0.x <= 751)) model_err++;
                if (v0.video_on !== (v0.x < 640 && v0.y < 480)) model_err++;
                if (v0.x > 799) model_err++;
                if (v0.y == 1) begin y1_at = c; y1_x = v0.x; end
                prev_x = v0.x; prev_vid = int'(v0.video_on);
            end
            chk("line_hs_low_clks", 32'(hs_lo), 384);
            chk("line_hs_first_x", 32'(hs_first), 656);
            chk("line_hs_last_x", 32'(hs_last), 751);
            chk("line_vid_fall_x", 32'(vid_fall), 640);
            chk("line_vid_fall_prev_x", 32'(fall_prev_x), 639);
            chk("line_model", 32'(model_err), 0);
            chk("line_y1_edge", 32'(y1_at), 3201);
            chk("line_y1_x", 32'(y1_x), 0);

            // Second line: length and per-pixel hold time.
            prev_x = 0; run = 1;
            while (c < 8000 && y2_at < 0) begin
                @(negedge clk); c++;
                if (v0.y == 2) y2_at = c;
                else if (v0.x == prev_x) run++;
                else begin
                    if (run != 4) run_err++;
                    run = 1; prev_x = v0.x;
                end
            end
            if (run != 4) run_err++;
            chk("line2_len", 32'(y2_at - y1_at), 3200);
            chk("line2_hold", 32'(run_err), 0);
        end

        // Two whole frames on the shrunken instance.
        begin
            int g = 0, ft = 0, ft_pos = 0, vs = 0, pt = 0, refr = 0, err = 0;
            bit prev_ref = 0, cur;
            while (g < 1000 && !v1.frame_tick) begin @(negedge clk); g++; end
            chk("frm_first_tick_found", 32'(v1.frame_tick), 1);
            for (int i = 0; i < 480; i++) begin
                ft += int'(v1.frame_tick);
                if (v1.frame_tick && (v1.x != 0 || v1.y != 0)) ft_pos++;
                vs += int'(!v1.vsync);
                pt += int'(v1.p_tick);
                cur = (v1.x == 0 && v1.y == 5);
                if (cur && !prev_ref) refr++;
                prev_ref = cur;
                if (v1.vsync !== !(v1.y >= 5 && v1.y <= 6)) err++;
                if (v1.hsync !== !(v1.x >= 10 && v1.x <= 12)) err++;
                if (v1.video_on !== (v1.x < 8 && v1.y < 4)) err++;
                if (v1.x > 14 || v1.y > 7) err++;
                @(negedge clk);
            end
            chk("frm_ticks", 32'(ft), 2);
            chk("frm_tick_at_origin", 32'(ft_pos), 0);
            chk("frm_vs_low_clks", 32'(vs), 120);
            chk("frm_ptick_cnt", 32'(pt), 240);
            chk("frm_refresh_pt", 32'(refr), 2);
            chk("frm_model", 32'(err), 0);
            chk("frm_period", 32'(v1.frame_tick), 1);
        end

        // Reset in the middle of the hsync pulse, divider at 2.
        begin
            int g = 0, hs_bad = 0;
            while (g < 4000 && v0.x != 700) begin @(negedge clk); g++; end
            chk("mid_found_x700", 32'(v0.x), 700);
            @(negedge clk);
            chk("mid_pre_hs", 32'(v0.hsync), 0);
            #2;
            startup("mid");
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!v0.hsync) hs_bad++;
            end
            chk("mid_no_partial_hs", 32'(hs_bad), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Timing generator that drives the pixel/paddle/ball renderer. It produces the x/y scan coordinates, video_on, and active-low hsync/vsync for 640x480@60 Hz VGA. It divides the 100 MHz board clock into a 25 MHz pixel-enable and emits a one-clock frame_tick per frame. The renderer consumes x, y and video_on directly, and the monitor connector consumes hsync/vsync.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels); H_TOTAL = sum of the four = 800
V_DISPLAY, 480, visible lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines); V_TOTAL = sum of the four = 525
CLK_DIV, 4, system clocks per pixel; must be 2 or more

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-low reset
p_tick  output  1  pixel enable: high for one clk every CLK_DIV clocks
x  output  10  current horizontal count, 0..H_TOTAL-1
y  output  10  current vertical count, 0..V_TOTAL-1
video_on  output  1  high when x < H_DISPLAY and y < V_DISPLAY
hsync  output  1  horizontal sync, active-low
vsync  output  1  vertical sync, active-low
frame_tick  output  1  one-clk pulse when counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0)

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on port reset. While reset=0, all state is forced immediately; operation starts on the first clk edge after release.
- Reset values: divider=0, x=0, y=0, p_tick=0, frame_tick=0, hsync=1, vsync=1, video_on=1 (because (0,0) is a visible pixel).
- All outputs are registers; there are no combinational paths to outputs.
- Divider: counts 0..CLK_DIV-1 and wraps. p_tick is registered high during the clk cycle in which the divider holds CLK_DIV-1.
- First p_tick after reset release: high in cycle CLK_DIV (the 4th clk edge with the defaults).
- Counters advance only on edges where p_tick=1:
  - x increments; at x=H_TOTAL-1 it wraps to 0.
  - y increments only when x wraps; at y=V_TOTAL-1 (coincident with the x wrap) it wraps to 0.
- video_on, hsync and vsync are computed from the next x/y values and registered on the same edge, so they are always aligned with the x/y presented in that cycle.
  - hsync=0 iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751 with defaults).
  - vsync=0 iff V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491 with defaults).
- frame_tick is set on the edge where both counters wrap to 0 and is high for exactly one clk. Period: H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clocks.
- Each x value holds for exactly CLK_DIV clocks. Each line is 3200 clocks.
- y=481, x=0 (the renderer's refresh point) occurs exactly once per frame.
- Width rule: 10-bit counters cover 799/524. Comparisons are unsigned; no value above H_TOTAL-1 or V_TOTAL-1 is ever produced.
- Reset mid-operation: an asynchronous return to the reset values regardless of divider phase. The count restarts cleanly with no partial-width sync pulse afterwards, because the counters are back at 0 where syncs are high.
- The block has no inputs besides clk and reset; it free-runs.

Test Plan:
- Assert reset=0 for 3 clk, then release -> x=0, y=0, hsync=1, vsync=1, video_on=1, p_tick=0 during reset. First p_tick on the 4th clk after release; x=1 on the following edge.
- Run one line -> video_on falls when x goes 639->640. hsync is low for exactly 96 pixels (x=656..751 = 384 clk). After x=799 the next x is 0 and y increments 0->1.
- Run to line end at y=479 -> y goes to 480 with video_on=0 for the whole line. vsync is low only for y=490 and 491 (1600 pixels = 6400 clk).
- Run two full frames -> frame_tick pulses exactly twice, 1,680,000 clk apart, each one clk wide. At each pulse x=0 and y=0. The pair (x=0, y=481) is seen once per frame.
- Assert reset mid-hsync (x=700, y=200) with the divider at 2 -> outputs immediately return to reset values asynchronously. After release, timing matches the first scenario exactly.
- Override CLK_DIV=2 -> p_tick every 2 clk, and frame_tick period is 840,000 clk.
